// File: rtl/lenet_fc_scheduler_if.sv
// lenet_fc_scheduler_if
// Serial parameter stream (biases, then weights) feeding the FC scheduler.
//   p_valid : source has a parameter beat
//   p_ready : scheduler accepts the beat this cycle
//   p_data  : signed parameter beat, WW bits
// master = parameter source, slave = scheduler.
interface lenet_fc_scheduler_if #(
  parameter int WW = 8
);
  logic          p_valid;
  logic          p_ready;
  logic [WW-1:0] p_data;

  modport master (output p_valid, output p_data, input p_ready);
  modport slave  (input p_valid, input p_data, output p_ready);
endinterface

// File: rtl/lenet_fc_scheduler.sv
// lenet_fc_scheduler
// Sequencer for one fully-connected layer made of N_OUT parallel neuron slices.
// Configuration: biases then channel-major weights arrive on the parameter
// stream and are broadcast on the W_*/B_* buses (each slice latches its own
// channel). Inference: N_IN activations are read from the feature buffer and
// streamed to all slices as one unbroken burst, then the scheduler waits for
// the slice result and leaves a 3-cycle gap for accumulators to clear.
//
// Ports
//   i_sclk, i_rstn        clock, async active-low reset
//   i_cfg_start           pulse: begin parameter load (IDLE or READY)
//   prm (slave)           parameter stream p_valid/p_ready/p_data
//   o_cfg_done            sticky: all parameters loaded
//   o_B_en/num/Bias       registered bias write strobe, channel, value
//   o_W_en/num/addr/Weight registered weight write strobe, channel, address, value
//   i_run                 pulse: start one inference (READY only)
//   o_fm_rd_en/addr       feature-buffer read, data returns one cycle later
//   i_fm_rd_data          feature-buffer read data
//   o_valid, o_tdata      activation stream to the slices
//   i_res_valid           result valid from slice 0
//   o_busy                high outside IDLE/READY
//   o_done                1-cycle pulse: inference complete
//   o_err                 sticky result-timeout flag, cleared by i_cfg_start
//
// Build option: define FC_SCHED_TIMEOUT_EN to abandon WAIT_RES after TO_CYC
// cycles without a result (sets o_err, no o_done). Without it WAIT_RES waits
// indefinitely and o_err is constant 0.
module lenet_fc_scheduler #(
  parameter int N_IN   = 120,
  parameter int N_OUT  = 84,
  parameter int WD     = 3,
  parameter int WW     = 8,
  parameter int TO_CYC = 16
) (
  input  logic                 i_sclk,
  input  logic                 i_rstn,
  input  logic                 i_cfg_start,
  lenet_fc_scheduler_if.slave  prm,
  output logic                 o_cfg_done,
  output logic                 o_B_en,
  output logic [7:0]           o_B_num,
  output logic [WW-1:0]        o_Bias,
  output logic                 o_W_en,
  output logic [7:0]           o_W_num,
  output logic [7:0]           o_W_addr,
  output logic [WW-1:0]        o_Weight,
  input  logic                 i_run,
  output logic                 o_fm_rd_en,
  output logic [7:0]           o_fm_rd_addr,
  input  logic [WD-1:0]        i_fm_rd_data,
  output logic                 o_valid,
  output logic [WD-1:0]        o_tdata,
  input  logic                 i_res_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  if (N_IN < 1 || N_IN > 256) begin : g_bad_n_in
    $error("lenet_fc_scheduler: N_IN must be 1..256");
  end
  if (N_OUT < 1 || N_OUT > 256) begin : g_bad_n_out
    $error("lenet_fc_scheduler: N_OUT must be 1..256");
  end
  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("lenet_fc_scheduler: TO_CYC must be at least 1");
  end

  // Last-index constants; comparing against N-1 keeps N=256 inside 8 bits.
  localparam logic [7:0] LAST_CH   = 8'(N_OUT - 1);
  localparam logic [7:0] LAST_ADDR = 8'(N_IN - 1);
  localparam logic [1:0] GAP_LAST  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_LOAD_W,
    S_READY,
    S_FETCH,
    S_WAIT_RES,
    S_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ch_q, addr_q;
  logic [1:0] gap_q;
  logic       p_ready_c;
  logic       beat;
  logic       to_hit;

  assign prm.p_ready = p_ready_c;
  assign beat        = prm.p_valid & p_ready_c;
  assign o_tdata     = i_fm_rd_data;
  assign o_busy      = !(state_q == S_IDLE || state_q == S_READY);

`ifdef FC_SCHED_TIMEOUT_EN
  localparam int            TW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic [TW-1:0] to_cnt_q;
  logic          err_q;

  // A result arriving on the final counted cycle still wins over the timeout.
  assign to_hit = (state_q == S_WAIT_RES) && !i_res_valid && (to_cnt_q == TO_LAST);
  assign o_err  = err_q;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != S_WAIT_RES) begin
        to_cnt_q <= '0;
      end else if (!i_res_valid) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (to_hit) begin
        err_q <= 1'b1;
      end else if (state_q == S_READY && i_cfg_start) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign to_hit = 1'b0;
  assign o_err  = 1'b0;
`endif

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cfg_start) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        p_ready_c = 1'b1;
        if (beat && ch_q == LAST_CH) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        p_ready_c = 1'b1;
        if (beat && ch_q == LAST_CH && addr_q == LAST_ADDR) state_d = S_READY;
      end
      S_READY: begin
        // Reconfiguration takes priority over a simultaneous run request.
        if (i_cfg_start)  state_d = S_LOAD_B;
        else if (i_run)   state_d = S_FETCH;
      end
      S_FETCH: begin
        if (o_fm_rd_addr == LAST_ADDR) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (i_res_valid || to_hit) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      ch_q         <= '0;
      addr_q       <= '0;
      gap_q        <= '0;
      o_cfg_done   <= 1'b0;
      o_B_en       <= 1'b0;
      o_B_num      <= '0;
      o_Bias       <= '0;
      o_W_en       <= 1'b0;
      o_W_num      <= '0;
      o_W_addr     <= '0;
      o_Weight     <= '0;
      o_fm_rd_en   <= 1'b0;
      o_fm_rd_addr <= '0;
      o_valid      <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_B_en  <= 1'b0;
      o_W_en  <= 1'b0;
      // Read data returns one cycle after the enable, so valid is the delayed enable.
      o_valid <= o_fm_rd_en;
      o_done  <= (state_q == S_WAIT_RES) && i_res_valid;
      case (state_q)
        S_IDLE, S_READY: begin
          if (i_cfg_start) begin
            ch_q       <= '0;
            addr_q     <= '0;
            o_cfg_done <= 1'b0;
          end else if (state_q == S_READY && i_run) begin
            o_fm_rd_en   <= 1'b1;
            o_fm_rd_addr <= '0;
          end
        end
        S_LOAD_B: begin
          if (beat) begin
            o_B_en  <= 1'b1;
            o_B_num <= ch_q;
            o_Bias  <= prm.p_data;
            ch_q    <= (ch_q == LAST_CH) ? 8'd0 : ch_q + 8'd1;
          end
        end
        S_LOAD_W: begin
          if (beat) begin
            o_W_en   <= 1'b1;
            o_W_num  <= ch_q;
            o_W_addr <= addr_q;
            o_Weight <= prm.p_data;
            if (addr_q == LAST_ADDR) begin
              addr_q <= '0;
              if (ch_q == LAST_CH) begin
                ch_q       <= '0;
                o_cfg_done <= 1'b1;
              end else begin
                ch_q <= ch_q + 8'd1;
              end
            end else begin
              addr_q <= addr_q + 8'd1;
            end
          end
        end
        S_FETCH: begin
          if (o_fm_rd_addr == LAST_ADDR) begin
            o_fm_rd_en   <= 1'b0;
            o_fm_rd_addr <= '0;
          end else begin
            o_fm_rd_addr <= o_fm_rd_addr + 8'd1;
          end
        end
        S_WAIT_RES: begin
          gap_q <= '0;
        end
        S_GAP: begin
          gap_q <= gap_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_fc_scheduler.sv
module tb_lenet_fc_scheduler;

  localparam int NC = 40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Small instance: N_OUT=2, N_IN=3
  logic       cfg_start = 1'b0, run = 1'b0, res_valid = 1'b0;
  logic       cfg_done, B_en, W_en, fm_rd_en, valid, busy, done, err;
  logic [7:0] B_num, Bias, W_num, W_addr, Weight, fm_rd_addr;
  logic [2:0] fm_rd_data, tdata;
  logic [2:0] fm [0:3];

  lenet_fc_scheduler_if #(.WW(8)) pif ();

  lenet_fc_scheduler #(.N_IN(3), .N_OUT(2), .WD(3), .WW(8), .TO_CYC(16)) dut (
    .i_sclk(clk), .i_rstn(rstn), .i_cfg_start(cfg_start), .prm(pif),
    .o_cfg_done(cfg_done), .o_B_en(B_en), .o_B_num(B_num), .o_Bias(Bias),
    .o_W_en(W_en), .o_W_num(W_num), .o_W_addr(W_addr), .o_Weight(Weight),
    .i_run(run), .o_fm_rd_en(fm_rd_en), .o_fm_rd_addr(fm_rd_addr),
    .i_fm_rd_data(fm_rd_data), .o_valid(valid), .o_tdata(tdata),
    .i_res_valid(res_valid), .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Edge instance: N_OUT=1, N_IN=256
  logic       e_cfg = 1'b0, e_run = 1'b0, e_res = 1'b0;
  logic       e_cfg_done, e_B_en, e_W_en, e_rd_en, e_valid, e_busy, e_done, e_err;
  logic [7:0] e_B_num, e_Bias, e_W_num, e_W_addr, e_Weight, e_rd_addr;
  logic [2:0] e_rd_data = 3'd0, e_tdata;

  lenet_fc_scheduler_if #(.WW(8)) epif ();

  lenet_fc_scheduler #(.N_IN(256), .N_OUT(1), .WD(3), .WW(8), .TO_CYC(16)) dut_e (
    .i_sclk(clk), .i_rstn(rstn), .i_cfg_start(e_cfg), .prm(epif),
    .o_cfg_done(e_cfg_done), .o_B_en(e_B_en), .o_B_num(e_B_num), .o_Bias(e_Bias),
    .o_W_en(e_W_en), .o_W_num(e_W_num), .o_W_addr(e_W_addr), .o_Weight(e_Weight),
    .i_run(e_run), .o_fm_rd_en(e_rd_en), .o_fm_rd_addr(e_rd_addr),
    .i_fm_rd_data(e_rd_data), .o_valid(e_valid), .o_tdata(e_tdata),
    .i_res_valid(e_res), .o_busy(e_busy), .o_done(e_done), .o_err(e_err)
  );

  // Feature buffer with one-cycle read latency
  always @(posedge clk) if (fm_rd_en) fm_rd_data <= fm[fm_rd_addr[1:0]];

  // Strobe capture on the small instance
  logic [15:0] bq [$];
  logic [23:0] wq [$];
  int          rd_cnt = 0;
  always @(negedge clk) begin
    if (B_en) bq.push_back({B_num, Bias});
    if (W_en) wq.push_back({W_num, W_addr, Weight});
    if (fm_rd_en) rd_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle trace of one inference, index = negedges after i_run was driven
  logic       rd_t [NC], v_t [NC], dn_t [NC], bz_t [NC], er_t [NC];
  logic [7:0] ad_t [NC];
  logic [2:0] td_t [NC];

  task automatic do_run(input bit give_res, input bit poke);
    int fall;
    bit seen_v;
    fall   = -1;
    seen_v = 1'b0;
    @(negedge clk);
    run = 1'b1;
    for (int c = 1; c < NC; c++) begin
      @(negedge clk);
      run       = poke && (c == 6 || c == 10 || c == 11);
      res_valid = 1'b0;
      rd_t[c] = fm_rd_en;  ad_t[c] = fm_rd_addr;  v_t[c] = valid;  td_t[c] = tdata;
      dn_t[c] = done;      bz_t[c] = busy;        er_t[c] = err;
      if (valid) seen_v = 1'b1;
      else if (seen_v && fall < 0) fall = c;
      if (give_res && fall >= 0 && c == fall + 3) res_valid = 1'b1;
    end
    run       = 1'b0;
    res_valid = 1'b0;
  endtask

  function automatic int count_done();
    int n;
    n = 0;
    for (int c = 1; c < NC; c++) if (dn_t[c]) n++;
    return n;
  endfunction

  task automatic cfg_load(input bit pulse, input bit run_in_w);
    logic [15:0] eb [2];
    logic [23:0] ew [6];
    int          rd0;
    eb[0] = 16'h0001; eb[1] = 16'h0102;
    ew[0] = 24'h000003; ew[1] = 24'h000104; ew[2] = 24'h000205;
    ew[3] = 24'h010006; ew[4] = 24'h010107; ew[5] = 24'h010208;
    bq.delete();
    wq.delete();
    rd0 = rd_cnt;
    if (pulse) begin
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    for (int v = 1; v <= 8; v++) begin
      if (v % 2 == 1) begin
        run = run_in_w && (v == 5);
        @(negedge clk);
        run = 1'b0;
      end
      pif.p_valid = 1'b1;
      pif.p_data  = 8'(v);
      if (v == 4) chk("p_ready_load", pif.p_ready, 1);
      @(negedge clk);
      pif.p_valid = 1'b0;
    end
    chk("cfg_done_set", cfg_done, 1);
    chk("busy_ready", busy, 0);
    chk("p_ready_ready", pif.p_ready, 0);
    @(negedge clk);
    chk("b_count", bq.size(), 2);
    chk("w_count", wq.size(), 6);
    for (int i = 0; i < 2 && i < bq.size(); i++) chk($sformatf("b_wr%0d", i), bq[i], eb[i]);
    for (int i = 0; i < 6 && i < wq.size(); i++) chk($sformatf("w_wr%0d", i), wq[i], ew[i]);
    chk("no_fetch_in_load", rd_cnt - rd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, bad, exp_a, vcnt, seen;
    fm[0] = 3'd2; fm[1] = 3'd5; fm[2] = 3'd7; fm[3] = 3'd0;
    pif.p_valid  = 1'b0; pif.p_data  = '0;
    epif.p_valid = 1'b0; epif.p_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p_ready", pif.p_ready, 0);
    chk("rst_B_en", B_en, 0);
    chk("rst_W_en", W_en, 0);
    chk("rst_rd_en", fm_rd_en, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;

    // i_run in IDLE is ignored
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    chk("idle_run_ignored", busy, 0);

    // Configuration, with an i_run pulse during LOAD_W
    cfg_load(1'b1, 1'b1);

    // Inference with buffer {2,5,7}
    do_run(1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("rd_en_c%0d", c), rd_t[c], 1);
      chk($sformatf("rd_addr_c%0d", c), ad_t[c], c - 1);
    end
    chk("rd_en_c4", rd_t[4], 0);
    chk("valid_c1", v_t[1], 0);
    chk("valid_c5", v_t[5], 0);
    for (int c = 2; c <= 4; c++) chk($sformatf("valid_c%0d", c), v_t[c], 1);
    chk("tdata_c2", td_t[2], 2);
    chk("tdata_c3", td_t[3], 5);
    chk("tdata_c4", td_t[4], 7);
    chk("done_count", count_done(), 1);
    chk("done_c9", dn_t[9], 1);
    chk("busy_c11", bz_t[11], 1);
    chk("busy_c12", bz_t[12], 0);

    // i_run during WAIT_RES and GAP is dropped
    rd0 = rd_cnt;
    do_run(1'b1, 1'b1);
    chk("poke_rd_cycles", rd_cnt - rd0, 3);
    chk("poke_done_count", count_done(), 1);
    chk("poke_idle_end", busy, 0);

    // i_run together with i_cfg_start in READY reconfigures
    @(negedge clk); run = 1'b1; cfg_start = 1'b1;
    @(negedge clk); run = 1'b0; cfg_start = 1'b0;
    chk("both_busy", busy, 1);
    chk("both_p_ready", pif.p_ready, 1);
    chk("both_no_fetch", fm_rd_en, 0);
    chk("both_cfg_cleared", cfg_done, 0);
    cfg_load(1'b0, 1'b0);

    // No result from the slices
    do_run(1'b0, 1'b0);
`ifdef FC_SCHED_TIMEOUT_EN
    chk("to_err_c19", er_t[19], 0);
    chk("to_err_c20", er_t[20], 1);
    chk("to_no_done", count_done(), 0);
    chk("to_busy_c22", bz_t[22], 1);
    chk("to_busy_c23", bz_t[23], 0);
    cfg_load(1'b1, 1'b0);
    chk("to_err_cleared", err, 0);
`else
    chk("wait_busy_c39", bz_t[NC-1], 1);
    chk("wait_err_c39", er_t[NC-1], 0);
    chk("wait_no_done", count_done(), 0);
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    cfg_load(1'b1, 1'b0);
`endif

    // Asynchronous reset on the second FETCH cycle
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    chk("fetch_c1", fm_rd_en, 1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("arst_rd_en", fm_rd_en, 0);
    chk("arst_rd_addr", fm_rd_addr, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cfg_done", cfg_done, 0);
    chk("arst_done", done, 0);
    chk("arst_B_en", B_en, 0);
    chk("arst_W_en", W_en, 0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); run = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      run = 1'b0;
      if (fm_rd_en || busy) seen++;
    end
    chk("arst_run_ignored", seen, 0);

    // Edge size N_IN=256, N_OUT=1
    @(negedge clk); e_cfg = 1'b1;
    @(negedge clk); e_cfg = 1'b0;
    for (int k = 0; k < 257; k++) begin
      epif.p_valid = 1'b1;
      epif.p_data  = 8'(k + 1);
      @(negedge clk);
      if (k == 255) chk("e_cfg_done_pre", e_cfg_done, 0);
    end
    epif.p_valid = 1'b0;
    chk("e_cfg_done", e_cfg_done, 1);
    chk("e_last_W_en", e_W_en, 1);
    chk("e_last_W_addr", e_W_addr, 255);
    chk("e_last_W_num", e_W_num, 0);
    chk("e_last_Weight", e_Weight, 1);
    @(negedge clk); e_run = 1'b1;
    bad = 0; exp_a = 0; vcnt = 0;
    for (int c = 0; c < 270; c++) begin
      @(negedge clk);
      e_run = 1'b0;
      if (e_rd_en) begin
        if (e_rd_addr != 8'(exp_a)) bad++;
        exp_a++;
      end
      if (e_valid) vcnt++;
    end
    chk("e_rd_count", exp_a, 256);
    chk("e_rd_addr_seq", bad, 0);
    chk("e_valid_count", vcnt, 256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
